// File: rtl/serial_frame_rx.sv
// ---------------------------------------------------------------------------
// serial_frame_rx
//
// Purpose:
//   Receives asynchronous-style serial frames one bit per bit_en strobe.
//   Frame: start bit (0), WIDTH data bits, optional even-parity bit, stop
//   bit (1). The received word is presented on Q with a valid/ready
//   handshake. Framing, parity and overrun problems are flagged by
//   single-cycle pulses.
//
// Configuration:
//   SERIAL_FRAME_RX_PARITY_EN - when defined, an even-parity bit follows
//   the data bits. When undefined there is no parity state and parity_err
//   is tied low. The port list is the same in both builds.
//
// Parameters:
//   WIDTH      - data bits per frame (2..16)
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous, active-high reset
//   sin        - serial line, idles high
//   bit_en     - bit strobe; sin is sampled only when this is 1
//   msb_first  - bit order of the next frame (0 = LSB first, 1 = MSB first)
//   Q          - received parallel word
//   valid      - Q holds a word not yet accepted
//   ready      - consumer accepts Q when valid and ready are both 1
//   frame_err  - one-cycle pulse: stop bit was 0
//   parity_err - one-cycle pulse: parity mismatch, word discarded
//   overrun    - one-cycle pulse: frame completed while Q was still held
//   busy       - receiver is inside a frame
// ---------------------------------------------------------------------------
module serial_frame_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             bit_en,
  input  logic             msb_first,
  output logic [WIDTH-1:0] Q,
  output logic             valid,
  input  logic             ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

`ifdef SERIAL_FRAME_RX_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;
`endif

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic             msb_lat, msb_lat_n;
  logic [WIDTH-1:0] q_r, q_n;
  logic             valid_r, valid_n;
  logic             ferr_r, ferr_n;
  logic             ovr_r, ovr_n;
  logic             complete;

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic             par_bad, par_bad_n;
  logic             perr_r, perr_n;
`endif

  // State register of the receive FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and datapath decisions. Everything holds by default; the
  // handshake is evaluated every cycle, the frame logic only on strobes.
  // A completing frame sees the handshake result first, so a word accepted
  // in the same cycle makes room for the new one instead of overrunning.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sr_n      = sr;
    msb_lat_n = msb_lat;
    q_n       = q_r;
    valid_n   = valid_r;
    ferr_n    = 1'b0;
    ovr_n     = 1'b0;
    complete  = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    par_bad_n = par_bad;
    perr_n    = 1'b0;
`endif

    if (valid_r && ready) begin
      valid_n = 1'b0;
    end

    if (bit_en) begin
      case (state)
        IDLE: begin
          if (!sin) begin
            state_n   = DATA;
            cnt_n     = '0;
            msb_lat_n = msb_first;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_bad_n = 1'b0;
`endif
          end
        end

        DATA: begin
          if (msb_lat) begin
            sr_n = {sr[WIDTH-2:0], sin};
          end else begin
            sr_n = {sin, sr[WIDTH-1:1]};
          end
          cnt_n = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end

`ifdef SERIAL_FRAME_RX_PARITY_EN
        // Even parity: the parity bit must equal the XOR of the data bits.
        PARITY: begin
          par_bad_n = (^sr) ^ sin;
          state_n   = STOP;
        end
`endif

        // A bad stop bit wins over a parity problem and never touches Q.
        STOP: begin
          state_n = IDLE;
          if (!sin) begin
            ferr_n = 1'b1;
          end else begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            if (par_bad) begin
              perr_n = 1'b1;
            end else begin
              complete = 1'b1;
            end
`else
            complete = 1'b1;
`endif
          end
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end

    // A finished word either replaces the output or, if the old word is
    // still held and not being accepted, is dropped with an overrun.
    if (complete) begin
      if (valid_r && !ready) begin
        ovr_n = 1'b1;
      end else begin
        q_n     = sr_n;
        valid_n = 1'b1;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      sr      <= '0;
      msb_lat <= 1'b0;
      q_r     <= '0;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      sr      <= sr_n;
      msb_lat <= msb_lat_n;
      q_r     <= q_n;
      valid_r <= valid_n;
      ferr_r  <= ferr_n;
      ovr_r   <= ovr_n;
    end
  end

`ifdef SERIAL_FRAME_RX_PARITY_EN
  // Parity tracking and its error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bad <= 1'b0;
      perr_r  <= 1'b0;
    end else begin
      par_bad <= par_bad_n;
      perr_r  <= perr_n;
    end
  end

  assign parity_err = perr_r;
`else
  assign parity_err = 1'b0;
`endif

  assign Q         = q_r;
  assign valid     = valid_r;
  assign frame_err = ferr_r;
  assign overrun   = ovr_r;
  assign busy      = (state != IDLE);

endmodule
